dm_port_arbiter: RTL and testbench

//   Shares the single-ported 64Kx16 data memory DM between two requesters:

---
 rtl/dm_arb_pkg.sv | 16 +
 rtl/dm_arb_pick.sv | 40 ++++
 rtl/dm_port_arbiter.sv | 122 ++++++++++++
 tb/tb_dm_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the DM port arbiter
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } owner_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DM_AW = 16;
  localparam int DM_DW = 16;

endpackage

// File: rtl/dm_arb_pick.sv
// rtl/dm_arb_pick.sv - combinational round-robin winner select with burst bound
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic          a_req_i,
  input  logic          b_req_i,
  input  owner_e        owner_i,
  input  logic          last_i,
  input  logic [CW-1:0] cnt_i,
  output logic          gnt_a_o,
  output logic          gnt_b_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (a_req_i && !b_req_i) begin
      gnt_a_o = 1'b1;
    end else if (b_req_i && !a_req_i) begin
      gnt_b_o = 1'b1;
    end else if (a_req_i && b_req_i) begin
      // Contention: the owner keeps the bus until its burst is used up.
      if (owner_i == OWN_A && cnt_i < MAX_CNT) begin
        gnt_a_o = 1'b1;
      end else if (owner_i == OWN_B && cnt_i < MAX_CNT) begin
        gnt_b_o = 1'b1;
      end else if (last_i == PORT_A) begin
        gnt_b_o = 1'b1;
      end else begin
        gnt_a_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - shares single-ported data memory DM between CPU (A) and loader (B)
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [DM_AW-1:0] a_addr,
  input  logic [DM_DW-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [DM_DW-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [DM_AW-1:0] b_addr,
  input  logic [DM_DW-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [DM_DW-1:0] b_rdata,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_re,
  output logic             dm_we,
  output logic [DM_DW-1:0] dm_wdata,
  input  logic [DM_DW-1:0] dm_rdata
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  owner_e           owner_q, owner_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_rvalid_q, b_rvalid_q;
  logic [DM_DW-1:0] a_rdata_q, b_rdata_q;
  logic             pick_a, pick_b;
  logic             a_rd, b_rd;

  dm_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_pick (
    .a_req_i (a_req),
    .b_req_i (b_req),
    .owner_i (owner_q),
    .last_i  (last_q),
    .cnt_i   (cnt_q),
    .gnt_a_o (pick_a),
    .gnt_b_o (pick_b)
  );

  assign a_gnt = pick_a & ~rst;
  assign b_gnt = pick_b & ~rst;
  assign a_rd  = a_gnt & ~a_we;
  assign b_rd  = b_gnt & ~b_we;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    if (a_gnt) begin
      dm_addr  = a_addr;
      dm_wdata = a_wdata;
      dm_re    = ~a_we;
      dm_we    = a_we;
    end else if (b_gnt) begin
      dm_addr  = b_addr;
      dm_wdata = b_wdata;
      dm_re    = ~b_we;
      dm_we    = b_we;
    end
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (a_gnt || b_gnt) begin
      if ((a_gnt && owner_q == OWN_A) || (b_gnt && owner_q == OWN_B)) begin
        if (cnt_q < MAX_CNT) cnt_d = cnt_q + CW'(1);
      end else begin
        owner_d = a_gnt ? OWN_A : OWN_B;
        last_d  = a_gnt ? PORT_A : PORT_B;
        cnt_d   = CW'(1);
      end
    end else begin
      owner_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= IDLE;
      last_q     <= PORT_B;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      // DM returns read data during the low phase, so it is ready at this edge.
      if (a_rd) a_rdata_q <= dm_rdata;
      if (b_rd) b_rdata_q <= dm_rdata;
    end
  end

  // A reset arriving right after a read grant cancels the pending return pulse.
  assign a_rvalid = a_rvalid_q & ~rst;
  assign b_rvalid = b_rvalid_q & ~rst;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - randomized self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_re, dm_we;

  int n_checks = 0;
  int n_fail   = 0;

  dm_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .dm_addr  (dm_addr),
    .dm_re    (dm_re),
    .dm_we    (dm_we),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: acts on the low phase of the clock.
  logic [15:0] dm_mem [0:65535];
  always @(negedge clk) begin
    if (dm_we) dm_mem[dm_addr] <= dm_wdata;
    if (dm_re) dm_rdata <= dm_mem[dm_addr];
  end

  // Reference model: shadow memory plus who-holds-the-bus bookkeeping.
  logic [15:0] sh_mem [0:65535];
  int          m_owner;   // 0 none, 1 A, 2 B
  int          m_streak;  // consecutive grants to m_owner
  int          m_last;    // 1 A, 2 B
  int          m_win;
  int          dut_g;
  logic        m_rv_a, m_rv_b;
  logic [15:0] m_rd_a, m_rd_b;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_streak = 0;
    m_last   = 2;
    m_rv_a   = 1'b0;
    m_rv_b   = 1'b0;
    m_rd_a   = 16'h0;
    m_rd_b   = 16'h0;
  endtask

  // Inputs are set by the caller just after a rising edge; check, then advance one cycle.
  task automatic do_cycle();
    logic [15:0] e_addr, e_wdata;
    logic        e_re, e_we;
    #2;
    if (rst) m_win = 0;
    else if (a_req && !b_req) m_win = 1;
    else if (b_req && !a_req) m_win = 2;
    else if (a_req && b_req) begin
      if (m_owner != 0 && m_streak < MAX_BURST) m_win = m_owner;
      else m_win = (m_last == 1) ? 2 : 1;
    end else m_win = 0;
    e_addr  = (m_win == 1) ? a_addr  : (m_win == 2) ? b_addr  : 16'h0;
    e_wdata = (m_win == 1) ? a_wdata : (m_win == 2) ? b_wdata : 16'h0;
    e_re    = (m_win == 1 && !a_we) || (m_win == 2 && !b_we);
    e_we    = (m_win == 1 && a_we) || (m_win == 2 && b_we);
    dut_g   = a_gnt ? 1 : (b_gnt ? 2 : 0);
    chk("a_gnt", 16'(a_gnt), 16'(m_win == 1));
    chk("b_gnt", 16'(b_gnt), 16'(m_win == 2));
    chk("dm_re", 16'(dm_re), 16'(e_re));
    chk("dm_we", 16'(dm_we), 16'(e_we));
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_wdata", dm_wdata, e_wdata);
    chk("re_we_excl", 16'(dm_re & dm_we), 16'h0);
    chk("gnt_excl", 16'(a_gnt & b_gnt), 16'h0);
    chk("a_rvalid", 16'(a_rvalid), 16'(m_rv_a && !rst));
    chk("b_rvalid", 16'(b_rvalid), 16'(m_rv_b && !rst));
    chk("a_rdata", a_rdata, m_rd_a);
    chk("b_rdata", b_rdata, m_rd_b);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_rv_a = (m_win == 1 && !a_we);
      m_rv_b = (m_win == 2 && !b_we);
      if (m_rv_a) m_rd_a = sh_mem[a_addr];
      if (m_rv_b) m_rd_b = sh_mem[b_addr];
      if (m_win == 1 && a_we) sh_mem[a_addr] = a_wdata;
      if (m_win == 2 && b_we) sh_mem[b_addr] = b_wdata;
      if (m_win == 0) begin
        m_owner  = 0;
        m_streak = 0;
      end else if (m_win == m_owner) begin
        m_streak++;
      end else begin
        m_owner  = m_win;
        m_last   = m_win;
        m_streak = 1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  int pat [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dm_mem[i] = 16'h0;
      sh_mem[i] = 16'h0;
    end
    model_reset();
    m_win = 0;
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;

    // Reset dominates simultaneous requests.
    do_cycle();
    do_cycle();
    rst = 1'b0;

    // A alone: write then read back.
    drive(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    do_cycle();
    chk("t2_rdata", a_rdata, 16'h1234);

    // Tie straight after reset goes to A first.
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    do_cycle();
    chk("t3_first", 16'(dut_g), 16'd1);
    a_req = 1'b0;
    do_cycle();
    chk("t3_second", 16'(dut_g), 16'd2);

    // Continuous contention: bounded bursts alternate owners.
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 16'(i), 16'h0, 1'b1, 1'b0, 16'(i + 16), 16'h0);
      do_cycle();
      chk("t4_pattern", 16'(dut_g), 16'(pat[i]));
    end

    // Reset right after a read grant cancels the return pulse.
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0003, 16'h0);
    do_cycle();
    rst = 1'b1;
    do_cycle();
    chk("t6_rvalid", 16'(b_rvalid), 16'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0004, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0);
    do_cycle();
    chk("t6_tie", 16'(dut_g), 16'd1);

    // Randomized traffic; a pending request keeps its fields until granted.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!(a_req && m_win != 1) || $urandom_range(0, 9) == 0) begin
        a_req   = ($urandom_range(0, 3) != 0);
        a_we    = ($urandom_range(0, 2) == 0);
        a_addr  = 16'($urandom_range(0, 15));
        a_wdata = 16'($urandom);
      end
      if (!(b_req && m_win != 2) || $urandom_range(0, 9) == 0) begin
        b_req   = ($urandom_range(0, 3) != 0);
        b_we    = ($urandom_range(0, 2) == 0);
        b_addr  = 16'($urandom_range(0, 15));
        b_wdata = 16'($urandom);
      end
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
